truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter SETTLE, default 1, sets the clock cycles each input vector is held before s is sampled; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
REQ-005 expected  input  16  reference minterm mask; bit i = required f(i).
REQ-006 s  input  1  output of the external 4-input function under test.
REQ-007 x, y, w, z  output  1 each  stimulus to the function under test; {x,y,w,z} = idx[3:0], x is the MSB.
REQ-008 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-009 done  output  1  one-cycle pulse when the scan is complete.
REQ-010 mask  output  16  captured truth table; bit i = sampled s for vector i.
REQ-011 ones  output  5  minterm count, range 0..16.
REQ-012 match  output  1  (mask == expected); valid from done until the next accepted start.

Function
REQ-013 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE with start=1: idx<=0, mask<=0, ones<=0, match<=0, cnt<=SETTLE-1, state<=SETTLE.
REQ-015 SETTLE: if cnt==0, go to SAMPLE; otherwise cnt<=cnt-1. x/y/w/z are held stable throughout.
REQ-016 SAMPLE: mask[idx]<=s and ones<=ones+s.
REQ-017 SAMPLE with idx==15: go to DONE.
REQ-018 SAMPLE with idx<15: idx<=idx+1, cnt<=SETTLE-1, go to SETTLE.
REQ-019 DONE: done=1 for exactly one cycle, match<=(mask==expected), then return to IDLE.
REQ-020 Latency: done is high in cycle 16*(SETTLE+1)+1 after the edge that accepts start. With SETTLE=1 this is cycle 33.
REQ-021 start while busy is ignored; the scan in progress is not disturbed.
REQ-022 start in the same cycle as DONE is ignored; start is accepted next in IDLE.
REQ-023 idx never wraps within a scan; vector 15 is followed only by DONE.
REQ-024 mask, ones and match hold their values in IDLE until the next accepted start.
REQ-025 expected is sampled only in DONE; changes at any other time have no effect.
REQ-026 ones is 5 bits wide so that the all-ones table gives 16 without overflow.

Reset
REQ-027 Reset forces, immediately and regardless of clk: state=IDLE, idx=0 (x=y=w=z=0), cnt=0, busy=0, done=0, mask=0, ones=0, match=0.
REQ-028 Reset mid-scan discards all partial results; the next start begins again at vector 0.
REQ-029 start is ignored while reset is high.

Structure
REQ-030 A shared package holds the FSM state typedef, NVEC=16, IDX_W=4 and ONES_W=5.
REQ-031 The block is one flat module; the function under test is external and is instantiated only in the bench.

Verification
REQ-032 Function with minterms {1,2,5,8,10,12,13}, expected=16'h3526, SETTLE=1, one start pulse -> done in cycle 33, mask=16'h3526, ones=7, match=1.
REQ-033 Same function with expected=16'h3527 -> mask=16'h3526, ones=7, match=0.
REQ-034 Constant-1 function, SETTLE=3 -> done in cycle 65, mask=16'hFFFF, ones=16. Constant-0 function -> mask=0, ones=0.
REQ-035 Assert reset at vector 7 of a scan -> all outputs go to 0 without waiting for clk. A fresh start then completes normally with correct results.
REQ-036 Pulse start again at cycles 5 and 33 of a scan -> both are ignored, exactly one done occurs, and {x,y,w,z} steps 0..15 monotonically with each value held SETTLE+1 cycles.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// Purpose: shared types and sizes for the truth-table scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package truth_table_scanner_pkg;

  localparam int NVEC   = 16;  // number of input vectors of a 4-input function
  localparam int IDX_W  = 4;   // vector index width, {x,y,w,z}
  localparam int ONES_W = 5;   // minterm count 0..16 needs 5 bits

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_t;

endpackage

// File: rtl/truth_table_scanner.sv
// Purpose: drives all 16 vectors into an external 4-input function, captures its truth table, counts minterms, compares to a reference.
// Latency: done pulses in cycle 16*(SETTLE+1)+1 after the edge that accepts start.
// Backpressure: none; start is a request honoured only in IDLE, ignored while a scan is running or finishing.
//
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   start           - one-cycle scan request
//   expected[15:0]  - reference minterm mask, sampled only in DONE
//   s               - output of the function under test
//   x, y, w, z      - stimulus, {x,y,w,z} = current vector index (x is the MSB)
//   busy, done      - scan in progress / one-cycle completion pulse
//   mask[15:0]      - captured truth table, bit i = f(i)
//   ones[4:0]       - number of minterms (0..16)
//   match           - mask == expected, valid from done until the next accepted start
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE = 1  // hold cycles per vector before sampling, 1..15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NVEC-1:0]     expected,
  input  logic                s,
  output logic                x,
  output logic                y,
  output logic                w,
  output logic                z,
  output logic                busy,
  output logic                done,
  output logic [NVEC-1:0]     mask,
  output logic [ONES_W-1:0]   ones,
  output logic                match
);

  localparam logic [3:0]       CNT_LOAD = 4'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVEC - 1);

  scan_state_t      state;
  scan_state_t      state_nxt;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cnt;
  logic             match_r;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == 4'd0) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = (idx == IDX_LAST) ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: index, settle counter, captured table and count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx     <= '0;
      cnt     <= '0;
      mask    <= '0;
      ones    <= '0;
      match_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx     <= '0;
            mask    <= '0;
            ones    <= '0;
            match_r <= 1'b0;
            cnt     <= CNT_LOAD;
          end
        end
        ST_SETTLE: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        ST_SAMPLE: begin
          mask[idx] <= s;
          ones      <= ones + ONES_W'(s);
          // Vector 15 is last; idx stays put so it never wraps inside a scan
          if (idx != IDX_LAST) begin
            idx <= idx + IDX_W'(1);
            cnt <= CNT_LOAD;
          end
        end
        ST_DONE: begin
          match_r <= (mask == expected);
        end
        default: ;
      endcase
    end
  end

  assign {x, y, w, z} = idx;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  // The comparison is presented live during the done pulse, then held from the register
  assign match        = (state == ST_DONE) ? (mask == expected) : match_r;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Purpose: directed self-checking bench for truth_table_scanner (SETTLE=1 and SETTLE=3 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_truth_table_scanner;

  logic        clk;
  logic        reset;
  logic        start1, start3;
  logic [15:0] expected;
  logic [15:0] fn_table;   // truth table of the modelled function under test

  logic        s1, x1, y1, w1, z1, busy1, done1, match1;
  logic [15:0] mask1;
  logic [4:0]  ones1;
  logic        s3, x3, y3, w3, z3, busy3, done3, match3;
  logic [15:0] mask3;
  logic [4:0]  ones3;

  int n_checks = 0;
  int n_fail   = 0;

  truth_table_scanner #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .expected(expected), .s(s1),
    .x(x1), .y(y1), .w(w1), .z(z1), .busy(busy1), .done(done1),
    .mask(mask1), .ones(ones1), .match(match1)
  );

  truth_table_scanner #(.SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .expected(expected), .s(s3),
    .x(x3), .y(y3), .w(w3), .z(z3), .busy(busy3), .done(done3),
    .mask(mask3), .ones(ones3), .match(match3)
  );

  // External combinational function under test
  always_comb begin
    s1 = fn_table[{x1, y1, w1, z1}];
    s3 = fn_table[{x3, y3, w3, z3}];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start on one instance and wait for done. With glitch set (SETTLE=1 only),
  // also pulse start in cycles 5 and 33 and check the stimulus stepping each cycle.
  task automatic run_scan(input bit use3, input bit glitch, output int cyc,
                          output logic [15:0] m_o, output logic [4:0] o_o, output logic mt_o);
    int         settle;
    int         exp_idx;
    bit         got;
    logic [3:0] v;
    settle = use3 ? 3 : 1;
    got    = 1'b0;
    cyc    = 0;
    m_o    = '0;
    o_o    = '0;
    mt_o   = 1'b0;
    @(negedge clk);
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start1 = 1'b0;
      start3 = 1'b0;
      if (glitch && cyc == 5) start1 = 1'b1;
      v = use3 ? {x3, y3, w3, z3} : {x1, y1, w1, z1};
      if (glitch) begin
        exp_idx = (cyc - 1) / (settle + 1);
        if (exp_idx > 15) exp_idx = 15;
        check_eq($sformatf("idx_step_c%0d", cyc), 32'(v), 32'(exp_idx));
      end
      if (use3 ? done3 : done1) begin
        got  = 1'b1;
        m_o  = use3 ? mask3 : mask1;
        o_o  = use3 ? ones3 : ones1;
        mt_o = use3 ? match3 : match1;
        if (glitch) start1 = 1'b1;  // start during DONE must be ignored
      end
    end
    check_eq("done_seen", 32'(got), 32'd1);
  endtask

  int          cyc;
  int          extra_done;
  int          budget;
  logic [15:0] m;
  logic [4:0]  o;
  logic        mt;

  initial begin
    reset    = 1'b1;
    start1   = 1'b0;
    start3   = 1'b0;
    expected = 16'h0000;
    fn_table = 16'h0000;
    #3;
    check_eq("rst_xywz1", 32'({x1, y1, w1, z1}), 32'd0);
    check_eq("rst_busy1", 32'(busy1), 32'd0);
    check_eq("rst_done1", 32'(done1), 32'd0);
    check_eq("rst_mask1", 32'(mask1), 32'd0);
    check_eq("rst_ones1", 32'(ones1), 32'd0);
    check_eq("rst_match1", 32'(match1), 32'd0);
    check_eq("rst_busy3", 32'(busy3), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Minterms {1,2,5,8,10,12,13}, with stray starts in cycles 5 and 33
    fn_table = 16'h3526;
    expected = 16'h3526;
    run_scan(1'b0, 1'b1, cyc, m, o, mt);
    check_eq("t1_latency", 32'(cyc), 32'd33);
    check_eq("t1_mask", 32'(m), 32'h3526);
    check_eq("t1_ones", 32'(o), 32'd7);
    check_eq("t1_match", 32'(mt), 32'd1);
    @(negedge clk);
    start1     = 1'b0;
    extra_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1) extra_done++;
    end
    check_eq("t1_extra_done", 32'(extra_done), 32'd0);
    check_eq("t1_busy_idle", 32'(busy1), 32'd0);
    check_eq("t1_match_hold", 32'(match1), 32'd1);
    check_eq("t1_mask_hold", 32'(mask1), 32'h3526);

    // Same function against a wrong reference
    expected = 16'h3527;
    run_scan(1'b0, 1'b0, cyc, m, o, mt);
    check_eq("t2_latency", 32'(cyc), 32'd33);
    check_eq("t2_mask", 32'(m), 32'h3526);
    check_eq("t2_ones", 32'(o), 32'd7);
    check_eq("t2_match", 32'(mt), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("t2_ones_hold", 32'(ones1), 32'd7);
    check_eq("t2_match_hold", 32'(match1), 32'd0);

    // Constant-1 function, SETTLE=3
    fn_table = 16'hFFFF;
    expected = 16'hFFFF;
    run_scan(1'b1, 1'b0, cyc, m, o, mt);
    check_eq("t3_latency", 32'(cyc), 32'd65);
    check_eq("t3_mask", 32'(m), 32'hFFFF);
    check_eq("t3_ones", 32'(o), 32'd16);
    check_eq("t3_match", 32'(mt), 32'd1);

    // Constant-0 function, SETTLE=3
    fn_table = 16'h0000;
    expected = 16'h0000;
    run_scan(1'b1, 1'b0, cyc, m, o, mt);
    check_eq("t4_mask", 32'(m), 32'h0000);
    check_eq("t4_ones", 32'(o), 32'd0);
    check_eq("t4_match", 32'(mt), 32'd1);

    // Reset in the middle of a scan, at vector 7
    fn_table = 16'h3526;
    expected = 16'h3526;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    budget = 0;
    do begin
      @(negedge clk);
      start1 = 1'b0;
      budget++;
    end while ({x1, y1, w1, z1} != 4'd7 && budget < 100);
    check_eq("t5_reached_vec7", 32'({x1, y1, w1, z1}), 32'd7);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_async_xywz", 32'({x1, y1, w1, z1}), 32'd0);
    check_eq("t5_async_busy", 32'(busy1), 32'd0);
    check_eq("t5_async_mask", 32'(mask1), 32'd0);
    check_eq("t5_async_ones", 32'(ones1), 32'd0);
    check_eq("t5_async_match", 32'(match1), 32'd0);
    check_eq("t5_async_done", 32'(done1), 32'd0);
    start1 = 1'b1;   // must be ignored while reset is high
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    check_eq("t5_start_in_reset", 32'(busy1), 32'd0);
    run_scan(1'b0, 1'b0, cyc, m, o, mt);
    check_eq("t5_latency", 32'(cyc), 32'd33);
    check_eq("t5_mask", 32'(m), 32'h3526);
    check_eq("t5_ones", 32'(o), 32'd7);
    check_eq("t5_match", 32'(mt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
